// File: rtl/m20k_dp_arbiter_if.sv
// Requester-side bus of the dual-port M20K arbiter: request handshake,
// read responses and the fill-complete flag.
interface m20k_dp_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 14
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        req_wdata;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_rdata;
    logic                   init_done;

    // Requester logic drives requests and observes grants/responses.
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, init_done
    );

    // The arbiter consumes requests and produces grants/responses.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, init_done
    );
endinterface

// File: rtl/m20k_dp_arbiter.sv
// Round-robin arbiter sharing one dual-port 16384x1 M20K between NREQ
// requesters: up to two grants per cycle (one per memory port), optional
// zero-fill of the whole array after reset, 1-cycle read latency.
module m20k_dp_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 14,
    parameter int INIT_EN = 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    m20k_dp_arbiter_if.slave    bus,
    output logic [ADDR_W-1:0]   A0,
    output logic [ADDR_W-1:0]   A1,
    output logic                D0,
    output logic                D1,
    output logic                CE0,
    output logic                CE1,
    output logic                WE0,
    output logic                WE1,
    output logic                WEM0,
    output logic                WEM1,
    input  logic                Q0,
    input  logic                Q1
);
    localparam int          PTR_W  = $clog2(NREQ);
    localparam int unsigned NREQ_U = NREQ;

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam state_t RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    state_t             state_q, state_d;
    logic [ADDR_W-2:0]  fill_q, fill_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               init_done_q;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0]    rsp_sel_q, rsp_sel_d;

    logic [ADDR_W-1:0]  addr_a [NREQ];
    logic               grant_en;
    logic               g0_vld, g1_vld;
    logic [PTR_W-1:0]   g0_idx, g1_idx;
    logic [PTR_W:0]     scan_sum;
    logic [PTR_W-1:0]   scan_idx;
    logic [PTR_W:0]     ptr_inc;
    logic [PTR_W-1:0]   last_idx;

    // Unpack the flat address bus into one entry per requester.
    always_comb begin
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            addr_a[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign grant_en = (state_q == ST_RUN) && init_done_q;

    // Round-robin scan from ptr: first valid takes port 0, first later
    // non-conflicting valid takes port 1.
    always_comb begin
        g0_vld   = 1'b0;
        g1_vld   = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int unsigned o = 0; o < NREQ_U; o++) begin
            scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(o);
            if (scan_sum >= (PTR_W+1)'(NREQ_U)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NREQ_U);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (grant_en && bus.req_valid[scan_idx]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = scan_idx;
                end else if (!g1_vld &&
                             !((addr_a[scan_idx] == addr_a[g0_idx]) &&
                               (bus.req_we[scan_idx] || bus.req_we[g0_idx]))) begin
                    g1_vld = 1'b1;
                    g1_idx = scan_idx;
                end
            end
        end
    end

    // Grant handshake and next pointer (one past the last granted index).
    always_comb begin
        bus.req_ready = '0;
        if (g0_vld) bus.req_ready[g0_idx] = 1'b1;
        if (g1_vld) bus.req_ready[g1_idx] = 1'b1;
        last_idx = g1_vld ? g1_idx : g0_idx;
        ptr_inc  = {1'b0, last_idx} + (PTR_W+1)'(1);
        if (ptr_inc == (PTR_W+1)'(NREQ_U)) begin
            ptr_d = '0;
        end else begin
            ptr_d = ptr_inc[PTR_W-1:0];
        end
    end

    // FSM next state, fill counter and memory pin drive.
    // Pins are masked by RST_N so they drop to 0 the moment reset asserts,
    // even though the reset state itself is INIT.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        A0   = '0;
        A1   = '0;
        D0   = 1'b0;
        D1   = 1'b0;
        CE0  = 1'b0;
        CE1  = 1'b0;
        WE0  = 1'b0;
        WE1  = 1'b0;
        WEM0 = 1'b0;
        WEM1 = 1'b0;
        case (state_q)
            ST_INIT: begin
                fill_d = fill_q + 1'b1;
                if (&fill_q) state_d = ST_RUN;
                if (RST_N) begin
                    A0   = {fill_q, 1'b0};
                    A1   = {fill_q, 1'b1};
                    CE0  = 1'b1;
                    CE1  = 1'b1;
                    WE0  = 1'b1;
                    WE1  = 1'b1;
                    WEM0 = 1'b1;
                    WEM1 = 1'b1;
                end
            end
            ST_RUN: begin
                if (g0_vld) begin
                    A0   = addr_a[g0_idx];
                    D0   = bus.req_wdata[g0_idx];
                    CE0  = 1'b1;
                    WE0  = bus.req_we[g0_idx];
                    WEM0 = bus.req_we[g0_idx];
                end
                if (g1_vld) begin
                    A1   = addr_a[g1_idx];
                    D1   = bus.req_wdata[g1_idx];
                    CE1  = 1'b1;
                    WE1  = bus.req_we[g1_idx];
                    WEM1 = bus.req_we[g1_idx];
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    // FSM state, fill counter, round-robin pointer and init flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= RST_STATE;
            fill_q      <= '0;
            ptr_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            init_done_q <= (state_d == ST_RUN);
            if (g0_vld) ptr_q <= ptr_d;
        end
    end

    // Read grants become next-cycle responses; remember which port served each.
    always_comb begin
        rsp_valid_d = '0;
        rsp_sel_d   = '0;
        if (g0_vld && !bus.req_we[g0_idx]) rsp_valid_d[g0_idx] = 1'b1;
        if (g1_vld && !bus.req_we[g1_idx]) begin
            rsp_valid_d[g1_idx] = 1'b1;
            rsp_sel_d[g1_idx]   = 1'b1;
        end
    end

    // Response valid and port-select registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsp_valid_q <= '0;
            rsp_sel_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sel_q   <= rsp_sel_d;
        end
    end

    // Steer memory read data to the requester, forced to 0 without a response.
    always_comb begin
        bus.rsp_valid = rsp_valid_q;
        bus.init_done = init_done_q;
        bus.rsp_rdata = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            bus.rsp_rdata[i] = rsp_valid_q[i] & (rsp_sel_q[i] ? Q1 : Q0);
        end
    end
endmodule

// File: tb/tb_m20k_dp_arbiter.sv
// Self-checking bench for m20k_dp_arbiter with a behavioural dual-port M20K
// and a rule-level arbitration/memory reference model.
module tb_m20k_dp_arbiter;
    localparam int NREQ   = 4;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int HALF   = DEPTH / 2;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic [ADDR_W-1:0] A0, A1;
    logic D0, D1, CE0, CE1, WE0, WE1, WEM0, WEM1;
    logic Q0, Q1;

    int n_tests = 0;
    int n_fail  = 0;

    bit mem [DEPTH];
    bit ref_mem [DEPTH];

    m20k_dp_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W)) bus ();

    m20k_dp_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .INIT_EN(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(bus),
        .A0(A0), .A1(A1), .D0(D0), .D1(D1), .CE0(CE0), .CE1(CE1),
        .WE0(WE0), .WE1(WE1), .WEM0(WEM0), .WEM1(WEM1), .Q0(Q0), .Q1(Q1)
    );

    always #5 CLK = ~CLK;

    // Behavioural M20K: synchronous write, registered read data.
    always @(posedge CLK) begin
        if (CE0) begin
            if (WE0 && WEM0) mem[A0] <= D0;
            else Q0 <= mem[A0];
        end
        if (CE1) begin
            if (WE1 && WEM1) mem[A1] <= D1;
            else Q1 <= mem[A1];
        end
    end

    task automatic set_req(input int i, input bit v, input bit we, input logic [ADDR_W-1:0] a, input bit d);
        bus.req_valid[i] = v;
        bus.req_we[i]    = we;
        bus.req_wdata[i] = d;
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_wdata = '0;
        bus.req_addr  = '0;
    endtask

    task automatic test_reset();
        clear_reqs();
        bus.req_valid = '1;
        RST_N = 1'b0;
        #1;
        n_tests++;
        if ({CE0, CE1, WE0, WE1, WEM0, WEM1, D0, D1} !== 8'h00 || A0 !== '0 || A1 !== '0) begin
            n_fail++; $display("FAIL reset_pins: got ce/we/d=%b A0=%h A1=%h exp 0", {CE0, CE1, WE0, WE1, WEM0, WEM1, D0, D1}, A0, A1);
        end
        n_tests++;
        if (bus.init_done !== 1'b0 || bus.req_ready !== 4'b0000 || bus.rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_bus: got done=%b ready=%b rspv=%b exp 0", bus.init_done, bus.req_ready, bus.rsp_valid);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < HALF; k++) begin
            #1;
            n_tests++;
            if (A0 !== ADDR_W'(2*k) || A1 !== ADDR_W'(2*k+1)) begin
                n_fail++; $display("FAIL init_addr k=%0d: got A0=%h A1=%h exp %h %h", k, A0, A1, 2*k, 2*k+1);
            end
            n_tests++;
            if ({CE0, CE1, WE0, WE1, WEM0, WEM1, D0, D1} !== 8'hFC) begin
                n_fail++; $display("FAIL init_ctl k=%0d: got %b exp 11111100", k, {CE0, CE1, WE0, WE1, WEM0, WEM1, D0, D1});
            end
            n_tests++;
            if (bus.init_done !== 1'b0 || bus.req_ready !== 4'b0000) begin
                n_fail++; $display("FAIL init_busy k=%0d: got done=%b ready=%b exp 0 0000", k, bus.init_done, bus.req_ready);
            end
            @(negedge CLK);
        end
        clear_reqs();
        #1;
        n_tests++;
        if (bus.init_done !== 1'b1 || CE0 !== 1'b0 || CE1 !== 1'b0) begin
            n_fail++; $display("FAIL init_done: got done=%b ce=%b%b exp 1 00", bus.init_done, CE0, CE1);
        end
        @(negedge CLK);
        set_req(0, 1, 0, 14'h0000, 0);
        set_req(1, 1, 0, 14'h3FFF, 0);
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0011 || A0 !== 14'h0000 || A1 !== 14'h3FFF) begin
            n_fail++; $display("FAIL post_init_rd_grant: got ready=%b A0=%h A1=%h exp 0011 0000 3fff", bus.req_ready, A0, A1);
        end
        @(negedge CLK);
        clear_reqs();
        #1;
        n_tests++;
        if (bus.rsp_valid !== 4'b0011 || bus.rsp_rdata !== 4'b0000) begin
            n_fail++; $display("FAIL post_init_rd_data: got v=%b d=%b exp 0011 0000", bus.rsp_valid, bus.rsp_rdata);
        end
    endtask

    task automatic test_write_read();
        @(negedge CLK);
        set_req(0, 1, 1, 14'h1234, 1);
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0001 || A0 !== 14'h1234 || {CE0, WE0, WEM0, D0} !== 4'b1111 || CE1 !== 1'b0) begin
            n_fail++; $display("FAIL wr_grant: got ready=%b A0=%h ce/we/wem/d=%b ce1=%b", bus.req_ready, A0, {CE0, WE0, WEM0, D0}, CE1);
        end
        @(negedge CLK);
        set_req(0, 1, 0, 14'h1234, 0);
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0001 || {CE0, WE0, WEM0} !== 3'b100 || bus.rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL rd_grant: got ready=%b ce/we/wem=%b rspv=%b exp 0001 100 0000", bus.req_ready, {CE0, WE0, WEM0}, bus.rsp_valid);
        end
        @(negedge CLK);
        clear_reqs();
        #1;
        n_tests++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata !== 4'b0001) begin
            n_fail++; $display("FAIL raw_rsp: got v=%b d=%b exp 0001 0001", bus.rsp_valid, bus.rsp_rdata);
        end
        // single read from requester 3 brings the pointer back to 0
        @(negedge CLK);
        set_req(3, 1, 0, 14'h0001, 0);
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b1000 || bus.rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL req3_grant: got ready=%b rspv=%b exp 1000 0000", bus.req_ready, bus.rsp_valid);
        end
        @(negedge CLK);
        clear_reqs();
        #1;
        n_tests++;
        if (bus.rsp_valid !== 4'b1000 || bus.rsp_rdata !== 4'b0000) begin
            n_fail++; $display("FAIL req3_rsp: got v=%b d=%b exp 1000 0000", bus.rsp_valid, bus.rsp_rdata);
        end
    endtask

    task automatic test_round_robin();
        @(negedge CLK);
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, ADDR_W'(14'h0100 + i), 0);
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0011 || A0 !== 14'h0100 || A1 !== 14'h0101) begin
            n_fail++; $display("FAIL rr_c1: got ready=%b A0=%h A1=%h exp 0011 0100 0101", bus.req_ready, A0, A1);
        end
        @(negedge CLK);
        bus.req_valid[0] = 1'b0;
        bus.req_valid[1] = 1'b0;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b1100 || A0 !== 14'h0102 || A1 !== 14'h0103) begin
            n_fail++; $display("FAIL rr_c2: got ready=%b A0=%h A1=%h exp 1100 0102 0103", bus.req_ready, A0, A1);
        end
        n_tests++;
        if (bus.rsp_valid !== 4'b0011 || bus.rsp_rdata !== 4'b0000) begin
            n_fail++; $display("FAIL rr_rsp1: got v=%b d=%b exp 0011 0000", bus.rsp_valid, bus.rsp_rdata);
        end
        @(negedge CLK);
        clear_reqs();
        #1;
        n_tests++;
        if (bus.rsp_valid !== 4'b1100 || bus.rsp_rdata !== 4'b0000) begin
            n_fail++; $display("FAIL rr_rsp2: got v=%b d=%b exp 1100 0000", bus.rsp_valid, bus.rsp_rdata);
        end
        // pointer is 0 again: requester 0 must win port 0 over requester 3
        @(negedge CLK);
        set_req(0, 1, 0, 14'h0200, 0);
        set_req(3, 1, 0, 14'h0203, 0);
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b1001 || A0 !== 14'h0200 || A1 !== 14'h0203 || bus.rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL rr_ptr0: got ready=%b A0=%h A1=%h rspv=%b exp 1001 0200 0203 0000", bus.req_ready, A0, A1, bus.rsp_valid);
        end
        @(negedge CLK);
        clear_reqs();
        #1;
        n_tests++;
        if (bus.rsp_valid !== 4'b1001) begin
            n_fail++; $display("FAIL rr_ptr0_rsp: got v=%b exp 1001", bus.rsp_valid);
        end
    endtask

    task automatic test_conflict();
        @(negedge CLK);
        set_req(0, 1, 1, 14'h0010, 1);
        set_req(1, 1, 0, 14'h0010, 0);
        set_req(2, 1, 0, 14'h0020, 0);
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0101 || A0 !== 14'h0010 || WE0 !== 1'b1 || A1 !== 14'h0020 || WE1 !== 1'b0) begin
            n_fail++; $display("FAIL cf_c1: got ready=%b A0=%h WE0=%b A1=%h WE1=%b exp 0101 0010 1 0020 0", bus.req_ready, A0, WE0, A1, WE1);
        end
        @(negedge CLK);
        bus.req_valid[0] = 1'b0;
        bus.req_valid[2] = 1'b0;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0010 || A0 !== 14'h0010 || WE0 !== 1'b0 || CE1 !== 1'b0) begin
            n_fail++; $display("FAIL cf_c2: got ready=%b A0=%h WE0=%b CE1=%b exp 0010 0010 0 0", bus.req_ready, A0, WE0, CE1);
        end
        n_tests++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_rdata !== 4'b0000) begin
            n_fail++; $display("FAIL cf_rsp2: got v=%b d=%b exp 0100 0000", bus.rsp_valid, bus.rsp_rdata);
        end
        @(negedge CLK);
        clear_reqs();
        #1;
        n_tests++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_rdata !== 4'b0010) begin
            n_fail++; $display("FAIL cf_rsp1: got v=%b d=%b exp 0010 0010", bus.rsp_valid, bus.rsp_rdata);
        end
    endtask

    task automatic test_same_addr_read();
        @(negedge CLK);
        set_req(0, 1, 1, 14'h0ABC, 1);
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL sa_wr: got ready=%b exp 0001", bus.req_ready);
        end
        @(negedge CLK);
        clear_reqs();
        set_req(1, 1, 0, 14'h0ABC, 0);
        set_req(3, 1, 0, 14'h0ABC, 0);
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b1010 || A0 !== 14'h0ABC || A1 !== 14'h0ABC) begin
            n_fail++; $display("FAIL sa_rd_grant: got ready=%b A0=%h A1=%h exp 1010 0abc 0abc", bus.req_ready, A0, A1);
        end
        @(negedge CLK);
        clear_reqs();
        #1;
        n_tests++;
        if (bus.rsp_valid !== 4'b1010 || bus.rsp_rdata !== 4'b1010) begin
            n_fail++; $display("FAIL sa_rsp: got v=%b d=%b exp 1010 1010", bus.rsp_valid, bus.rsp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        // reset with a read response outstanding
        @(negedge CLK);
        set_req(2, 1, 0, 14'h0010, 0);
        @(negedge CLK);
        clear_reqs();
        #1;
        n_tests++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_rdata !== 4'b0100) begin
            n_fail++; $display("FAIL rm_pre: got v=%b d=%b exp 0100 0100", bus.rsp_valid, bus.rsp_rdata);
        end
        #1;
        RST_N = 1'b0;
        #1;
        n_tests++;
        if (bus.rsp_valid !== 4'b0000 || bus.rsp_rdata !== 4'b0000 || bus.init_done !== 1'b0) begin
            n_fail++; $display("FAIL rm_run_rst: got v=%b d=%b done=%b exp 0000 0000 0", bus.rsp_valid, bus.rsp_rdata, bus.init_done);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 100; k++) @(negedge CLK);
        #1;
        n_tests++;
        if (A0 !== 14'd200 || CE0 !== 1'b1) begin
            n_fail++; $display("FAIL rm_k100: got A0=%h CE0=%b exp 00c8 1", A0, CE0);
        end
        #1;
        RST_N = 1'b0;
        #1;
        n_tests++;
        if ({CE0, CE1, WE0, WE1, WEM0, WEM1, D0, D1} !== 8'h00 || A0 !== '0 || A1 !== '0) begin
            n_fail++; $display("FAIL rm_init_rst: got ctl=%b A0=%h A1=%h exp 0", {CE0, CE1, WE0, WE1, WEM0, WEM1, D0, D1}, A0, A1);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < HALF; k++) begin
            #1;
            n_tests++;
            if (A0 !== ADDR_W'(2*k) || bus.init_done !== 1'b0) begin
                n_fail++; $display("FAIL rm_refill k=%0d: got A0=%h done=%b exp %h 0", k, A0, bus.init_done, 2*k);
            end
            @(negedge CLK);
        end
        #1;
        n_tests++;
        if (bus.init_done !== 1'b1) begin
            n_fail++; $display("FAIL rm_done: got %b exp 1", bus.init_done);
        end
    endtask

    task automatic test_random();
        bit pv [NREQ];
        bit pw [NREQ];
        bit pd [NREQ];
        logic [ADDR_W-1:0] pa [NREQ];
        logic [NREQ-1:0] exp_rv = '0;
        logic [NREQ-1:0] exp_rd = '0;
        logic [NREQ-1:0] exp_ready;
        int ptr_m = 0;
        int g0, g1, gs;
        for (int i = 0; i < NREQ; i++) pv[i] = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge CLK);
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(9) < 7) begin
                    pv[i] = 1;
                    pw[i] = 1'($urandom_range(1));
                    pd[i] = 1'($urandom_range(1));
                    pa[i] = ADDR_W'(32'h2000 + $urandom_range(3));
                end
                set_req(i, pv[i], pw[i], pa[i], pd[i]);
            end
            #1;
            n_tests++;
            if (bus.rsp_valid !== exp_rv || bus.rsp_rdata !== exp_rd) begin
                n_fail++; $display("FAIL rnd_rsp cyc=%0d: got v=%b d=%b exp %b %b", cyc, bus.rsp_valid, bus.rsp_rdata, exp_rv, exp_rd);
            end
            g0 = -1;
            g1 = -1;
            for (int o = 0; o < NREQ; o++) begin
                int i;
                i = (ptr_m + o) % NREQ;
                if (pv[i]) begin
                    if (g0 < 0) g0 = i;
                    else if (g1 < 0 && !(pa[i] == pa[g0] && (pw[i] || pw[g0]))) g1 = i;
                end
            end
            exp_ready = '0;
            if (g0 >= 0) exp_ready[g0] = 1'b1;
            if (g1 >= 0) exp_ready[g1] = 1'b1;
            n_tests++;
            if (bus.req_ready !== exp_ready) begin
                n_fail++; $display("FAIL rnd_ready cyc=%0d: got %b exp %b", cyc, bus.req_ready, exp_ready);
            end
            n_tests++;
            if (CE0 !== (g0 >= 0) || CE1 !== (g1 >= 0) ||
                (g0 >= 0 && (A0 !== pa[g0] || WE0 !== pw[g0])) ||
                (g1 >= 0 && (A1 !== pa[g1] || WE1 !== pw[g1]))) begin
                n_fail++; $display("FAIL rnd_port cyc=%0d: got ce=%b%b A0=%h A1=%h exp grants %0d %0d", cyc, CE0, CE1, A0, A1, g0, g1);
            end
            exp_rv = '0;
            exp_rd = '0;
            for (int p = 0; p < 2; p++) begin
                gs = (p == 0) ? g0 : g1;
                if (gs >= 0 && !pw[gs]) begin
                    exp_rv[gs] = 1'b1;
                    exp_rd[gs] = ref_mem[pa[gs]];
                end
            end
            for (int p = 0; p < 2; p++) begin
                gs = (p == 0) ? g0 : g1;
                if (gs >= 0) begin
                    if (pw[gs]) ref_mem[pa[gs]] = pd[gs];
                    pv[gs] = 0;
                end
            end
            if (g0 >= 0) ptr_m = (((g1 >= 0) ? g1 : g0) + 1) % NREQ;
        end
        @(negedge CLK);
        clear_reqs();
        #1;
        n_tests++;
        if (bus.rsp_valid !== exp_rv || bus.rsp_rdata !== exp_rd) begin
            n_fail++; $display("FAIL rnd_rsp_last: got v=%b d=%b exp %b %b", bus.rsp_valid, bus.rsp_rdata, exp_rv, exp_rd);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 1'b1;
        test_reset();
        test_write_read();
        test_round_robin();
        test_conflict();
        test_same_addr_read();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
